// File: rtl/multicycle_control.sv
// multicycle_control
//
// Per-instruction sequencer for the NN CPU. Instruction fetch and data access
// share one memory port, and MAC runs its multiply and accumulate in separate
// cycles. The sequencer drives datapath strobes and ALU selects, and handles
// the memory handshake with an optional timeout. It also tracks sticky
// halt/error status and counts retired instructions.
//
// Parameters
//   CNT_W    width of the saturating retired-instruction counter
//   TIMEOUT  max cycles an access may wait for mem_ready (0 = no limit)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   opcode[3:0]           IR[15:12], sampled in DECODE only
//   mem_ready             completion of the current memory access
//   PCEn, IRWrite         PC increment / IR load (fetch completion cycle)
//   IorD                  memory address select (0 = PC, 1 = ALUOut)
//   MemRead, MemWrite     memory strobes
//   RegWrite, MemtoReg, RegDst, ALUSrc   datapath selects
//   ALUControl1/2[2:0]    ALU ops: 000 add, 001 mul, 010 slt, 111 idle
//   halted, illegal       sticky status flags
//   instr_count           retired instructions, saturating
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic             PCEn,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic [2:0]       ALUControl1,
  output logic [2:0]       ALUControl2,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_SINN = 4'b0011;
  localparam logic [3:0] OP_MAC  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ST   = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_MUL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_IDLE = 3'b111;

  localparam int WAIT_W = $clog2(TIMEOUT + 2);
  // Last stalled count before the access is abandoned.
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_ADDR, S_MEMRD,
    S_MEMWR, S_WB, S_WBM, S_HALTED, S_ERR
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] op_reg, op_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] instr_count_reg;

  // Registered Moore outputs: loaded with the decode of the state being
  // entered, so they line up with the state register without output glitches.
  logic iord_reg, mem_read_reg, mem_write_reg, reg_write_reg;
  logic memto_reg_reg, reg_dst_reg, alu_src_reg, halted_reg, illegal_reg;
  logic [2:0] alu1_reg, alu2_reg;
  logic iord_next, mem_read_next, mem_write_next, reg_write_next;
  logic memto_reg_next, reg_dst_next, alu_src_next, halted_next, illegal_next;
  logic [2:0] alu1_next, alu2_next;

  logic in_access, done, timed_out, retire;
  logic [3:0] dec_op;

  // An access is live only while its strobe is actually driven; right after
  // reset the state is FETCH but the strobe register is still clear, so the
  // first fetch starts one cycle later and mem_ready is not accepted yet.
  assign in_access = ((state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                      (state_reg == S_MEMWR)) && (mem_read_reg || mem_write_reg);
  assign done      = in_access && mem_ready;
  assign timed_out = (TIMEOUT != 0) && in_access && !mem_ready &&
                     (wait_cnt_reg == TO_LAST);

  // While in DECODE the held opcode is not latched yet, so use the live one.
  assign dec_op = (state_reg == S_DECODE) ? opcode : op_reg;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (done)           state_next = S_DECODE;
        else if (timed_out) state_next = S_ERR;
      end
      S_DECODE: begin
        op_next = opcode;
        case (opcode)
          OP_NOP: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_ADD, OP_ADDI, OP_MUL, OP_SINN, OP_MAC: state_next = S_EXEC;
          OP_LD, OP_ST:                            state_next = S_ADDR;
          OP_HALT: begin
            retire     = 1'b1;
            state_next = S_HALTED;
          end
          default: state_next = S_ERR;
        endcase
      end
      S_EXEC:  state_next = (op_reg == OP_MAC) ? S_EXEC2 : S_WB;
      S_EXEC2: state_next = S_WB;
      S_ADDR:  state_next = (op_reg == OP_ST) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (done)           state_next = S_WBM;
        else if (timed_out) state_next = S_ERR;
      end
      S_MEMWR: begin
        if (done) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (timed_out) begin
          state_next = S_ERR;
        end
      end
      S_WB, S_WBM: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: state_next = S_HALTED;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_ERR;
    endcase
  end

  always_comb begin
    iord_next      = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    reg_write_next = 1'b0;
    memto_reg_next = 1'b0;
    reg_dst_next   = 1'b0;
    alu_src_next   = 1'b0;
    halted_next    = 1'b0;
    illegal_next   = 1'b0;
    alu1_next      = ALU_IDLE;
    alu2_next      = ALU_IDLE;
    case (state_next)
      S_FETCH: mem_read_next = 1'b1;
      S_EXEC: begin
        case (dec_op)
          OP_MUL, OP_MAC: alu1_next = ALU_MUL;
          OP_SINN:        alu1_next = ALU_SLT;
          default:        alu1_next = ALU_ADD;
        endcase
        alu_src_next = (dec_op == OP_ADDI);
      end
      S_EXEC2: begin
        alu1_next = ALU_MUL;
        alu2_next = ALU_ADD;
      end
      S_ADDR: begin
        alu1_next    = ALU_ADD;
        alu_src_next = 1'b1;
      end
      S_MEMRD: begin
        mem_read_next = 1'b1;
        iord_next     = 1'b1;
      end
      S_MEMWR: begin
        mem_write_next = 1'b1;
        iord_next      = 1'b1;
      end
      S_WB: begin
        reg_write_next = 1'b1;
        memto_reg_next = 1'b1;
        reg_dst_next   = 1'b1;
      end
      S_WBM:    reg_write_next = 1'b1;
      S_HALTED: halted_next = 1'b1;
      S_ERR:    illegal_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      op_reg          <= OP_NOP;
      wait_cnt_reg    <= '0;
      instr_count_reg <= '0;
      iord_reg        <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      reg_write_reg   <= 1'b0;
      memto_reg_reg   <= 1'b0;
      reg_dst_reg     <= 1'b0;
      alu_src_reg     <= 1'b0;
      halted_reg      <= 1'b0;
      illegal_reg     <= 1'b0;
      alu1_reg        <= ALU_IDLE;
      alu2_reg        <= ALU_IDLE;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      iord_reg      <= iord_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      reg_write_reg <= reg_write_next;
      memto_reg_reg <= memto_reg_next;
      reg_dst_reg   <= reg_dst_next;
      alu_src_reg   <= alu_src_next;
      halted_reg    <= halted_next;
      illegal_reg   <= illegal_next;
      alu1_reg      <= alu1_next;
      alu2_reg      <= alu2_next;
      // Wait counter restarts whenever a new state is entered.
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (in_access && !mem_ready)
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      if (retire && (instr_count_reg != {CNT_W{1'b1}}))
        instr_count_reg <= instr_count_reg + CNT_W'(1);
    end
  end

  // Fetch completion strobes follow mem_ready in the same cycle.
  assign PCEn        = (state_reg == S_FETCH) && done;
  assign IRWrite     = (state_reg == S_FETCH) && done;
  assign IorD        = iord_reg;
  assign MemRead     = mem_read_reg;
  assign MemWrite    = mem_write_reg;
  assign RegWrite    = reg_write_reg;
  assign MemtoReg    = memto_reg_reg;
  assign RegDst      = reg_dst_reg;
  assign ALUSrc      = alu_src_reg;
  assign ALUControl1 = alu1_reg;
  assign ALUControl2 = alu2_reg;
  assign halted      = halted_reg;
  assign illegal     = illegal_reg;
  assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed per-cycle vectors. Each step
// drives reset/opcode/mem_ready for one cycle and queues the hand-computed
// control word and instr_count for that cycle; a monitor pops and compares
// on the falling edge.
module tb_multicycle_control;

  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset, mem_ready;
  logic [3:0] opcode;
  logic PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, RegDst, ALUSrc;
  logic [2:0] ALUControl1, ALUControl2;
  logic halted, illegal;
  logic [CW-1:0] instr_count;

  multicycle_control #(.CNT_W(CW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCEn(PCEn), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUControl1(ALUControl1),
    .ALUControl2(ALUControl2), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {PCEn,IRWrite,IorD,MemRead,MemWrite,RegWrite,MemtoReg,RegDst,ALUSrc,ALU1,ALU2,halted,illegal}
  localparam logic [16:0] E_IDLE = {9'b000000000, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_FW   = {9'b000100000, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_FR   = {9'b110100000, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_ADD  = {9'b000000000, 3'b000, 3'b111, 2'b00};
  localparam logic [16:0] E_ADDI = {9'b000000001, 3'b000, 3'b111, 2'b00};
  localparam logic [16:0] E_ADDR = {9'b000000001, 3'b000, 3'b111, 2'b00};
  localparam logic [16:0] E_MUL  = {9'b000000000, 3'b001, 3'b111, 2'b00};
  localparam logic [16:0] E_SINN = {9'b000000000, 3'b010, 3'b111, 2'b00};
  localparam logic [16:0] E_EX2  = {9'b000000000, 3'b001, 3'b000, 2'b00};
  localparam logic [16:0] E_MRD  = {9'b001100000, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_MWR  = {9'b001010000, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_WB   = {9'b000001110, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_WBM  = {9'b000001000, 3'b111, 3'b111, 2'b00};
  localparam logic [16:0] E_HALT = {9'b000000000, 3'b111, 3'b111, 2'b10};
  localparam logic [16:0] E_ERR  = {9'b000000000, 3'b111, 3'b111, 2'b01};

  logic [16:0] exp_ctl_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  string exp_nm_q[$];

  int checks = 0;
  int passes = 0;

  logic [16:0] act_ctl;
  assign act_ctl = {PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
                    RegDst, ALUSrc, ALUControl1, ALUControl2, halted, illegal};

  logic [16:0] m_ctl;
  logic [CW-1:0] m_cnt;
  string m_nm;

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_ctl_q.size() > 0) begin
      m_ctl = exp_ctl_q.pop_front();
      m_cnt = exp_cnt_q.pop_front();
      m_nm  = exp_nm_q.pop_front();
      checks = checks + 1;
      if (act_ctl === m_ctl) passes = passes + 1;
      else $display("FAIL %s ctl: got %b want %b", m_nm, act_ctl, m_ctl);
      checks = checks + 1;
      if (instr_count === m_cnt) passes = passes + 1;
      else $display("FAIL %s instr_count: got %0d want %0d", m_nm, instr_count, m_cnt);
      $display("cycle %s ctl=%b cnt=%0d", m_nm, act_ctl, instr_count);
    end
  end

  task automatic step(input logic r, input logic [3:0] op, input logic mr,
                      input logic [16:0] e, input logic [CW-1:0] c, input string nm);
    @(posedge clk);
    #1;
    reset     = r;
    opcode    = op;
    mem_ready = mr;
    exp_ctl_q.push_back(e);
    exp_cnt_q.push_back(c);
    exp_nm_q.push_back(nm);
  endtask

  initial begin
    reset = 1'b1;
    opcode = 4'd0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // ADD x3 with mem_ready held high; PCEn at cycles 1, 5, 9.
    step(1, 4'd0, 1, E_IDLE, 0, "rst");
    step(0, 4'd0, 1, E_IDLE, 0, "c0_idle");
    step(0, 4'd0, 1, E_FR,   0, "c1_add1_f");
    step(0, 4'd1, 1, E_IDLE, 0, "c2_add1_d");
    step(0, 4'd0, 1, E_ADD,  0, "c3_add1_x");
    step(0, 4'd0, 1, E_WB,   0, "c4_add1_wb");
    step(0, 4'd0, 1, E_FR,   1, "c5_add2_f");
    step(0, 4'd1, 1, E_IDLE, 1, "add2_d");
    step(0, 4'd7, 1, E_ADD,  1, "add2_x");
    step(0, 4'd0, 1, E_WB,   1, "add2_wb");
    step(0, 4'd0, 1, E_FR,   2, "c9_add3_f");
    step(0, 4'd1, 1, E_IDLE, 2, "add3_d");
    step(0, 4'd0, 1, E_ADD,  2, "add3_x");
    step(0, 4'd0, 1, E_WB,   2, "add3_wb");
    // MAC
    step(0, 4'd0, 1, E_FR,   3, "mac_f");
    step(0, 4'd4, 1, E_IDLE, 3, "mac_d");
    step(0, 4'd0, 1, E_MUL,  3, "mac_x");
    step(0, 4'd0, 1, E_EX2,  3, "mac_x2");
    step(0, 4'd0, 1, E_WB,   3, "mac_wb");
    // LD with three wait cycles (one below the timeout)
    step(0, 4'd0,  1, E_FR,   4, "ld_f");
    step(0, 4'd14, 1, E_IDLE, 4, "ld_d");
    step(0, 4'd0,  1, E_ADDR, 4, "ld_addr");
    step(0, 4'd0,  0, E_MRD,  4, "ld_mrd_w1");
    step(0, 4'd0,  0, E_MRD,  4, "ld_mrd_w2");
    step(0, 4'd0,  0, E_MRD,  4, "ld_mrd_w3");
    step(0, 4'd0,  1, E_MRD,  4, "ld_mrd_ok");
    step(0, 4'd0,  1, E_WBM,  4, "ld_wbm");
    // ADDI
    step(0, 4'd0, 1, E_FR,   5, "addi_f");
    step(0, 4'd9, 1, E_IDLE, 5, "addi_d");
    step(0, 4'd0, 1, E_ADDI, 5, "addi_x");
    step(0, 4'd0, 1, E_WB,   5, "addi_wb");
    // NOP x2, counter saturates at 7
    step(0, 4'd0, 1, E_FR,   6, "nop1_f");
    step(0, 4'd0, 1, E_IDLE, 6, "nop1_d");
    step(0, 4'd0, 1, E_FR,   7, "nop2_f");
    step(0, 4'd0, 1, E_IDLE, 7, "nop2_d");
    // SINN
    step(0, 4'd0, 1, E_FR,   7, "sinn_f_sat");
    step(0, 4'd3, 1, E_IDLE, 7, "sinn_d");
    step(0, 4'd0, 1, E_SINN, 7, "sinn_x");
    step(0, 4'd0, 1, E_WB,   7, "sinn_wb");
    // HALT, then stimulus that must be ignored
    step(0, 4'd0,  1, E_FR,   7, "halt_f");
    step(0, 4'd11, 1, E_IDLE, 7, "halt_d");
    step(0, 4'd1,  1, E_HALT, 7, "halted1");
    step(0, 4'd0,  0, E_HALT, 7, "halted2");
    step(0, 4'd0,  1, E_HALT, 7, "halted3");

    // ST then an unknown opcode
    step(1, 4'd0,  1, E_HALT, 7, "rst_h");
    step(0, 4'd0,  1, E_IDLE, 0, "st_idle");
    step(0, 4'd0,  1, E_FR,   0, "st_f");
    step(0, 4'd15, 1, E_IDLE, 0, "st_d");
    step(0, 4'd0,  1, E_ADDR, 0, "st_addr");
    step(0, 4'd0,  1, E_MWR,  0, "st_mwr");
    step(0, 4'd0,  1, E_FR,   1, "bad_f");
    step(0, 4'd7,  1, E_IDLE, 1, "bad_d");
    step(0, 4'd1,  1, E_ERR,  1, "err1");
    step(0, 4'd0,  0, E_ERR,  1, "err2");
    step(0, 4'd0,  1, E_ERR,  1, "err3");

    // Fetch timeout with mem_ready stuck low
    step(1, 4'd0, 0, E_ERR,  1, "rst_e");
    step(0, 4'd0, 0, E_IDLE, 0, "to_idle");
    step(0, 4'd0, 0, E_FW,   0, "to_w1");
    step(0, 4'd0, 0, E_FW,   0, "to_w2");
    step(0, 4'd0, 0, E_FW,   0, "to_w3");
    step(0, 4'd0, 0, E_FW,   0, "to_w4");
    step(0, 4'd0, 0, E_ERR,  0, "to_err1");
    step(0, 4'd0, 1, E_ERR,  0, "to_err2");

    // Cleared counter after reset, then reset in the middle of MEMRD
    step(1, 4'd0,  0, E_ERR,  0, "rst_e2");
    step(0, 4'd0,  0, E_IDLE, 0, "rd_idle");
    step(0, 4'd0,  0, E_FW,   0, "rd_fw1");
    step(0, 4'd0,  0, E_FW,   0, "rd_fw2");
    step(0, 4'd0,  0, E_FW,   0, "rd_fw3");
    step(0, 4'd0,  1, E_FR,   0, "rd_fr");
    step(0, 4'd14, 0, E_IDLE, 0, "rd_d");
    step(0, 4'd0,  0, E_ADDR, 0, "rd_addr");
    step(0, 4'd0,  0, E_MRD,  0, "rd_mrd");
    step(1, 4'd0,  0, E_MRD,  0, "rd_rst");
    step(0, 4'd0,  0, E_IDLE, 0, "rd_after_rst");
    step(0, 4'd0,  0, E_FW,   0, "re_fw");
    step(0, 4'd0,  1, E_FR,   0, "re_fr");
    step(0, 4'd0,  1, E_IDLE, 0, "re_nop_d");
    step(0, 4'd0,  1, E_FR,   1, "re_next_f");

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_ctl_q.size() == 0) passes = passes + 1;
    else $display("FAIL drain: got %0d pending want 0", exp_ctl_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
